s1111442_alu_arb: RTL

S1111442_ALU_ARB -- requirements
Module: s1111442_alu_arb

---
 rtl/s1111442_alu_arb.sv | 120 ++++++++++++
 1 files changed

// File: rtl/s1111442_alu_arb.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU.
// Optional build macro ALU_ARB_STATS_EN adds per-requester response counters cnt0/cnt1.
module s1111442_alu_arb #(
   parameter int HOLD_CYC = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,
   input  logic [1:0] req0_sel,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,
   input  logic [1:0] req1_sel,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [1:0] alu_sel,
   input  logic [4:0] alu_res,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [4:0] rsp_data,
   output logic       rsp_id
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [7:0] cnt0,
   output logic [7:0] cnt1
`endif
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [1:0] HOLD_LAST = 2'(HOLD_CYC - 1);

   state_t     state;
   logic       last_grant;
   logic       op_id;
   logic [1:0] hold_cnt;
   logic       grant0;
   logic       grant1;

   // Requester 0 wins a tie unless it was the one granted last.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state == IDLE) begin
         if (req0_valid && (!req1_valid || last_grant))
            grant0 = 1'b1;
         else if (req1_valid)
            grant1 = 1'b1;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         op_id      <= 1'b0;
         hold_cnt   <= 2'd0;
         alu_a      <= 4'd0;
         alu_b      <= 4'd0;
         alu_sel    <= 2'd0;
         rsp_valid  <= 1'b0;
         rsp_data   <= 5'd0;
         rsp_id     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  alu_a      <= grant1 ? req1_a   : req0_a;
                  alu_b      <= grant1 ? req1_b   : req0_b;
                  alu_sel    <= grant1 ? req1_sel : req0_sel;
                  op_id      <= grant1;
                  last_grant <= grant1;
                  hold_cnt   <= 2'd0;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               if (hold_cnt == HOLD_LAST) begin
                  rsp_data  <= alu_res;
                  rsp_id    <= op_id;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  hold_cnt <= hold_cnt + 2'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_ARB_STATS_EN
   // Counters wrap naturally at 8 bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt0 <= 8'd0;
         cnt1 <= 8'd0;
      end else if (rsp_valid && rsp_ready) begin
         if (rsp_id)
            cnt1 <= cnt1 + 8'd1;
         else
            cnt0 <= cnt0 + 8'd1;
      end
   end
`endif

endmodule
